// File: rtl/nmr_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package     : nmr_seq_pkg
// Description : Shared types and default widths for the NMR pulse-sequence
//               delay timer.
// Revision    : 1.0 - initial release
// ============================================================================
package nmr_seq_pkg;

  // Default width of the delay value; matches the delay_t1 parameter register.
  localparam int DEF_CNT_W  = 32;
  // Default width of the completed-delay counter.
  localparam int DEF_RUNS_W = 16;

  // Delay timer sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : nmr_seq_pkg
`default_nettype wire

// File: rtl/nmr_delay_cnt.sv
`default_nettype none
// ============================================================================
// Module      : nmr_delay_cnt
// Description : Loadable down-counter with clear, load and decrement controls
//               and a flag that marks the final counted cycle (count == 1).
//               Priority: clear > load > dec.
// Revision    : 1.0 - initial release
// ============================================================================
module nmr_delay_cnt
  import nmr_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             is_one
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over a reload, which wins over a decrement.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (dec) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign is_one = (count_q == CNT_W'(1));

endmodule : nmr_delay_cnt
`default_nettype wire

// File: rtl/nmr_delay_timer.sv
`default_nettype none
// ============================================================================
// Module      : nmr_delay_timer
// Description : Captures the delay_t1 value on a sequencer start request,
//               counts that many clk cycles (busy), then emits a one-cycle
//               done pulse and bumps a wrapping completed-delay count.
//               Optional feature macro: NMR_DELAY_TIMER_REMAINING_EN adds the
//               'remaining' readback port.
// Revision    : 1.0 - initial release
// ============================================================================
module nmr_delay_timer
  import nmr_seq_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int RUNS_W = DEF_RUNS_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CNT_W-1:0]  delay_val,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [RUNS_W-1:0] runs
`ifdef NMR_DELAY_TIMER_REMAINING_EN
  ,
  output logic [CNT_W-1:0]  remaining
`endif
);

  state_e            state_q;
  state_e            state_d;
  logic [RUNS_W-1:0] runs_q;
  logic [RUNS_W-1:0] runs_d;

  logic              w_accept;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_clear;
  logic [CNT_W-1:0]  cnt_count;
  logic              cnt_is_one;

  // Abort always overrides a coincident start request.
  assign w_accept = start && !abort;

  nmr_delay_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (delay_val),
    .dec      (cnt_dec),
    .clear    (cnt_clear),
    .count    (cnt_count),
    .is_one   (cnt_is_one)
  );

  // Next-state, counter control and completed-run accounting.
  always_comb begin
    state_d   = state_q;
    runs_d    = runs_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          // A zero-length delay skips COUNT and completes on the next cycle.
          cnt_load = 1'b1;
          state_d  = (delay_val == '0) ? DONE : COUNT;
        end
      end
      COUNT: begin
        if (abort) begin
          cnt_clear = 1'b1;
          state_d   = IDLE;
        end else if (cnt_count == '0) begin
          // Unreachable in normal operation; recover instead of wrapping
          // through 2^CNT_W cycles if the counter is ever corrupted.
          cnt_clear = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_is_one) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // The run is complete once DONE is left; abort cannot cancel it.
        runs_d  = runs_q + RUNS_W'(1);
        state_d = IDLE;
        if (w_accept) begin
          cnt_load = 1'b1;
          state_d  = (delay_val == '0) ? DONE : COUNT;
        end
      end
      default: begin
        cnt_clear = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  // State and run-count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      runs_q  <= '0;
    end else begin
      state_q <= state_d;
      runs_q  <= runs_d;
    end
  end

  assign busy = (state_q == COUNT);
  assign done = (state_q == DONE);
  assign runs = runs_q;

`ifdef NMR_DELAY_TIMER_REMAINING_EN
  // Counter value is only meaningful while counting; report 0 otherwise.
  assign remaining = (state_q == COUNT) ? cnt_count : '0;
`endif

endmodule : nmr_delay_timer
`default_nettype wire

// File: doc/nmr_delay_timer.md
Name: nmr_delay_timer

Overview:
- Consumer of the 32-bit delay_t1 parameter register output (Avalon-MM PIO `out_port`) in the NMR pulse-sequence path.
- On a start trigger from the sequencer it captures delay_t1 and counts exactly that many clock cycles.
- It then issues a one-cycle done pulse that advances the sequencer to the next pulse/acquisition phase.
- It also reports busy status and a wrapping count of completed delays for software/debug readback.

Parameters:
- CNT_W, 32, width of delay value and down-counter; must match the parameter register width.
- RUNS_W, 16, width of completed-delay counter.

Ports:
- clk  input  1  system clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- delay_val  input  CNT_W  delay length in clk cycles; driven from the delay_t1 register out_port.
- start  input  1  single-cycle request to begin a delay.
- abort  input  1  cancel an in-progress delay.
- busy  output  1  high while counting.
- done  output  1  one-cycle pulse at delay completion.
- runs  output  RUNS_W  number of completed (non-aborted) delays, wraps.
- remaining  output  CNT_W  cycles left in the current delay (present only with the optional feature).

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk release):
  - state=IDLE, counter=0, busy=0, done=0, runs=0, remaining=0.
- State machine: IDLE, COUNT, DONE.
- IDLE:
  - start=1 and abort=0 at edge k: latch delay_val as N.
  - N>=1: counter<=N, go COUNT.
  - N==0: go DONE directly.
- COUNT:
  - busy=1.
  - Each edge decrements counter.
  - When counter==1 at an edge: go DONE.
  - busy is high for exactly N cycles, k+1 through k+N.
- DONE:
  - done=1 for exactly one cycle (cycle k+N+1; cycle k+1 when N=0).
  - runs increments at the edge leaving DONE.
  - Next state is IDLE, or reload exactly as IDLE would if start=1 in this cycle (back-to-back delays, no idle gap).
- Outputs busy and done are registered; each is a decode of the state register only.
- delay_val is sampled only on accepted start; later changes to it do not affect a running delay.
- start during COUNT: ignored, no queuing.
- abort:
  - In COUNT: go IDLE at the next edge, counter<=0, no done, runs unchanged.
  - In DONE: no effect on that done pulse.
  - In IDLE: no effect.
  - abort and start in the same cycle: abort wins, start discarded.
- runs wraps from 2^RUNS_W-1 to 0 with no flag.
- Counter arithmetic is unsigned CNT_W bits; no underflow is possible because exit happens at counter==1.
- N=2^CNT_W-1 must count fully.
- Reset asserted mid-COUNT: immediate return to reset values; no done is emitted.

Optional Feature:
- Macro: NMR_DELAY_TIMER_REMAINING_EN.
- Defined:
  - Output remaining is present.
  - It equals the counter value while in COUNT, and 0 in IDLE and DONE.
  - It is registered, same timing as the counter.
- Undefined:
  - The remaining port and its logic are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package nmr_seq_pkg holds:
  - state enum {IDLE, COUNT, DONE};
  - CNT_W default constant;
  - RUNS_W default constant.
- One natural sub-module: nmr_delay_cnt. It is a loadable down-counter with load, dec and clear inputs, a count output and an is_one flag. The FSM and runs counter stay in the top level.

Test Plan:
- delay_val=5, start pulse at edge k -> busy high cycles k+1..k+5, done single pulse at k+6, runs=1.
- delay_val=0, start -> busy never high, done at k+1, runs increments.
- delay_val=3, start; then start again during DONE with delay_val=2 -> second busy begins at the cycle after done, for 2 cycles, then done; runs=2.
- delay_val=10, start; abort at the 4th busy cycle -> busy low next cycle, no done, runs unchanged; start+abort same cycle in IDLE -> stays IDLE.
- delay_val=8, start, change delay_val to 1 mid-count, pulse start during COUNT, assert reset_n low at the 3rd busy cycle -> delay_val change and mid-count start have no effect; on reset busy=0, done=0, runs=0 immediately; no done after release.
- Preload runs at 16'hFFFF via 65535 zero-delay runs, one more run -> runs=0. With NMR_DELAY_TIMER_REMAINING_EN, delay_val=4 -> remaining reads 4,3,2,1 during busy, then 0.
